// File: rtl/signal_delay_ring.sv
// Programmable delay line: din delayed by 0..DEPTH-1 clocks through a RAM ring,
// with a valid flag that holds off until the selected tap holds real samples.
module signal_delay_ring #(
  parameter int unsigned DATA_W          = 8,
  parameter int unsigned DEPTH           = 1024,
  parameter int unsigned BLANK_ON_CHANGE = 1,
  localparam int unsigned AW             = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic [AW-1:0]     delay,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid
);

  localparam logic [AW-1:0] FILL_MAX = AW'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     fill;
  logic [AW-1:0]     delay_q;
  logic [AW-1:0]     rd_addr;
  logic [AW-1:0]     fill_eff;
  logic [AW-1:0]     fill_nxt;
  logic              change;
  logic              valid_nxt;
  logic [DATA_W-1:0] tap;

  // Tap selection, hold-off bookkeeping and next fill level
  always_comb begin
    change    = (delay != delay_q);
    fill_eff  = fill;
    if ((BLANK_ON_CHANGE != 0) && change) begin
      fill_eff = '0;
    end
    valid_nxt = (fill_eff >= delay);
    fill_nxt  = (fill_eff == FILL_MAX) ? fill_eff : fill_eff + AW'(1);
    rd_addr   = wr_ptr - delay;
    // delay=0 must bypass: the word for this edge is only being written now
    tap       = (delay == '0) ? din : mem[rd_addr];
  end

  // Ring write; contents are deliberately not reset, stale words are masked by valid
  always_ff @(posedge clk) begin
    mem[wr_ptr] <= din;
  end

  // Pointer, fill counter, delay history and registered output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      fill       <= '0;
      delay_q    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr + AW'(1);
      fill       <= fill_nxt;
      delay_q    <= delay;
      dout_valid <= valid_nxt;
      dout       <= valid_nxt ? tap : '0;
    end
  end

endmodule

// File: tb/tb_signal_delay_ring.sv
// Bench for signal_delay_ring: one blanking and one non-blanking instance fed the
// same stimulus, checked every cycle against a sample-history model.
module tb_signal_delay_ring;

  localparam int DW = 8;
  localparam int DP = 16;
  localparam int AWT = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [DW-1:0]  din = '0;
  logic [AWT-1:0] delay = '0;
  logic [DW-1:0]  dout_b, dout_n;
  logic           valid_b, valid_n;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: full din history since reset, edge count, last change edge
  logic [DW-1:0] hist [$];
  int n_edge = 0;
  int last_chg = 0;
  int prev_dly = 0;
  logic [DW-1:0] expb_dout = '0, expn_dout = '0;
  logic          expb_valid = 1'b0, expn_valid = 1'b0;

  signal_delay_ring #(.DATA_W(DW), .DEPTH(DP), .BLANK_ON_CHANGE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din), .delay(delay),
    .dout(dout_b), .dout_valid(valid_b)
  );

  signal_delay_ring #(.DATA_W(DW), .DEPTH(DP), .BLANK_ON_CHANGE(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .din(din), .delay(delay),
    .dout(dout_n), .dout_valid(valid_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int min_sat(input int a);
    return (a > DP - 1) ? DP - 1 : a;
  endfunction

  // Model update at each edge, then compare both instances shortly after
  always begin
    @(posedge clk);
    if (!rst_n) begin
      hist.delete();
      n_edge = 0; last_chg = 0; prev_dly = 0;
      expb_dout = '0; expn_dout = '0; expb_valid = 1'b0; expn_valid = 1'b0;
    end else begin
      int d, fn, fb;
      d = int'(delay);
      if (d != prev_dly) last_chg = n_edge;
      hist.push_back(din);
      fn = min_sat(n_edge);
      fb = min_sat(n_edge - last_chg);
      expn_valid = (fn >= d);
      expb_valid = (fb >= d);
      expn_dout  = expn_valid ? hist[n_edge - d] : '0;
      expb_dout  = expb_valid ? hist[n_edge - d] : '0;
      prev_dly = d;
      n_edge++;
    end
    #1;
    check($sformatf("dout_b e%0d", n_edge - 1), 32'(dout_b), 32'(expb_dout));
    check($sformatf("valid_b e%0d", n_edge - 1), 32'(valid_b), 32'(expb_valid));
    check($sformatf("dout_n e%0d", n_edge - 1), 32'(dout_n), 32'(expn_dout));
    check($sformatf("valid_n e%0d", n_edge - 1), 32'(valid_n), 32'(expn_valid));
  end

  // Present one edge worth of inputs, return just after that edge
  task automatic drive(input logic [DW-1:0] d, input logic [AWT-1:0] dl);
    din = d;
    delay = dl;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Literal pin: both the model and the DUT must equal a hand-derived value
  task automatic pin(input string name, input logic [31:0] model, input logic [31:0] act,
                     input logic [31:0] lit);
    check({"model ", name}, model, lit);
    check({"dut ", name}, act, lit);
  endtask

  initial begin
    logic [AWT-1:0] rd;
    repeat (2) @(posedge clk);
    #2;
    check("reset dout_b", 32'(dout_b), 0);
    check("reset valid_b", 32'(valid_b), 0);
    rst_n = 1'b1;

    // T1: bypass
    for (int k = 0; k < 20; k++) begin
      drive(DW'(k), 4'd0);
      if (k == 0) pin("T1 valid e0", 32'(expb_valid), 32'(valid_b), 1);
      if (k == 7) pin("T1 dout e7", 32'(expb_dout), 32'(dout_b), 7);
    end

    // T2: delay 5
    do_reset();
    for (int k = 0; k < 12; k++) begin
      drive(DW'(k), 4'd5);
      if (k == 4) pin("T2 valid e4", 32'(expb_valid), 32'(valid_b), 0);
      if (k == 5) pin("T2 valid e5", 32'(expb_valid), 32'(valid_b), 1);
      if (k == 5) pin("T2 dout e5", 32'(expb_dout), 32'(dout_b), 0);
      if (k == 9) pin("T2 dout e9", 32'(expb_dout), 32'(dout_b), 4);
    end

    // T3: maximum delay across wraps
    do_reset();
    for (int k = 0; k < 40; k++) begin
      drive(DW'(k), 4'd15);
      if (k == 14) pin("T3 valid e14", 32'(expn_valid), 32'(valid_n), 0);
      if (k == 15) pin("T3 dout e15", 32'(expn_dout), 32'(dout_n), 0);
      if (k == 39) pin("T3 dout e39", 32'(expn_dout), 32'(dout_n), 24);
    end

    // T4/T5: delay 3 -> 6 at edge 20
    do_reset();
    for (int k = 0; k < 32; k++) begin
      drive(DW'(k), (k < 20) ? 4'd3 : 4'd6);
      if (k == 20) pin("T4 valid e20", 32'(expb_valid), 32'(valid_b), 0);
      if (k == 25) pin("T4 valid e25", 32'(expb_valid), 32'(valid_b), 0);
      if (k == 26) pin("T4 dout e26", 32'(expb_dout), 32'(dout_b), 20);
      if (k == 26) pin("T4 valid e26", 32'(expb_valid), 32'(valid_b), 1);
      if (k == 20) pin("T5 dout e20", 32'(expn_dout), 32'(dout_n), 14);
      if (k == 20) pin("T5 valid e20", 32'(expn_valid), 32'(valid_n), 1);
      if (k == 21) pin("T5 dout e21", 32'(expn_dout), 32'(dout_n), 15);
    end

    // T6: asynchronous reset mid-ramp
    do_reset();
    for (int k = 0; k < 10; k++) drive(DW'(50 + k), 4'd4);
    rst_n = 1'b0;
    #1;
    check("T6 async dout_b", 32'(dout_b), 0);
    check("T6 async valid_b", 32'(valid_b), 0);
    check("T6 async dout_n", 32'(dout_n), 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(DW'(100 + k), 4'd4);
      if (k == 3) pin("T6 valid e3", 32'(expn_valid), 32'(valid_n), 0);
      if (k == 4) pin("T6 dout e4", 32'(expn_dout), 32'(dout_n), 100);
    end

    // Randomized: mostly steady delay with occasional jumps, one mid-run reset
    rd = 4'(($urandom_range(0, 15)));
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 15) == 0) rd = 4'($urandom_range(0, 15));
      if (k == 1500) do_reset();
      drive(DW'($urandom), rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
